// File: rtl/seq_detect_ctrl.sv
// Run-controlled serial pattern matcher: programmable pattern/length, overlap mode and match limit.
// Optional SEQ_DETECT_CTRL_TIMEOUT_EN adds a per-run inactivity timeout (cfg_timeout / timeout).
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  ,
  parameter int TO_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             timeout,
`endif
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             busy,
  output logic             detect,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic [1:0] {IDLE, ARM, SCAN, DONE} state_t;

  state_t             state;
  logic [PAT_W-1:0]   hist;
  logic [LEN_W-1:0]   fill;
  logic [PAT_W-1:0]   sh_pat;
  logic [LEN_W-1:0]   sh_len;
  logic               sh_ovl;
  logic [CNT_W-1:0]   sh_lim;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  logic [TO_W-1:0]    sh_to;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_nxt;
  logic               to_hit;
`endif

  logic               len_ok;
  logic               accept;
  logic [PAT_W-1:0]   hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [PAT_W-1:0]   mask;
  logic               hit;
  logic [CNT_W-1:0]   cnt_inc;
  logic               lim_hit;

  always_comb begin
    len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    accept   = (state == SCAN) && in_valid;
    hist_nxt = {hist[PAT_W-2:0], in_bit};
    fill_nxt = (fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill + 1'b1;
    mask     = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(sh_len));
    // Only the low len bits take part; older history is don't-care.
    hit      = accept && (fill_nxt >= sh_len) && (((hist_nxt ^ sh_pat) & mask) == '0);
    cnt_inc  = (match_count == '1) ? match_count : match_count + 1'b1;
    lim_hit  = hit && (sh_lim != '0) && (cnt_inc == sh_lim);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    to_nxt   = to_cnt + 1'b1;
    to_hit   = !hit && (sh_to != '0) && (to_nxt == sh_to);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      detect      <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
      hist        <= '0;
      fill        <= '0;
      sh_pat      <= '0;
      sh_len      <= '0;
      sh_ovl      <= 1'b0;
      sh_lim      <= '0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
      sh_to       <= '0;
      to_cnt      <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      detect  <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              sh_pat      <= cfg_pattern;
              sh_len      <= cfg_len;
              sh_ovl      <= cfg_overlap;
              sh_lim      <= cfg_limit;
              match_count <= '0;
              hist        <= '0;
              fill        <= '0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
              sh_to       <= cfg_timeout;
              to_cnt      <= '0;
`endif
              state       <= ARM;
              busy        <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ARM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= SCAN;
            in_ready <= 1'b1;
          end
        end
        SCAN: begin
          if (accept) begin
            hist <= hist_nxt;
            fill <= (hit && !sh_ovl) ? '0 : fill_nxt;
          end
          if (hit) begin
            detect      <= 1'b1;
            match_count <= cnt_inc;
          end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
          to_cnt <= hit ? '0 : to_nxt;
`endif
          // Abort wins over limit: the run ends without a done pulse.
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (lim_hit) begin
            state    <= DONE;
            done     <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
          end else if (to_hit) begin
            state    <= IDLE;
            timeout  <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b0;
`endif
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl (default build): match, overlap, limit, stalls, abort, cfg errors, reset.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, cfg_overlap, in_valid, in_bit;
  logic [7:0] cfg_pattern, cfg_limit;
  logic [3:0] cfg_len;
  logic       in_ready, busy, detect, done, cfg_err;
  logic [7:0] match_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_limit(cfg_limit), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .busy(busy), .detect(detect), .done(done),
    .cfg_err(cfg_err), .match_count(match_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bitin(input logic b, input logic exp_det, input string tag);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    chk(tag, 32'(detect), 32'(exp_det));
  endtask

  task automatic gap(input string tag);
    in_valid = 1'b0;
    tick();
    chk(tag, 32'(detect), 32'd0);
  endtask

  task automatic start_run(input logic [7:0] pat, input logic [3:0] len,
                           input logic ovl, input logic [7:0] lim);
    in_valid    = 1'b0;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_limit   = lim;
    start       = 1'b1;
    tick();
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_ready", 32'(in_ready), 32'd0);
    start       = 1'b0;
    cfg_len     = 4'd0;  // config may change freely after latching
    cfg_pattern = 8'h00;
    tick();
    chk("scan_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic abort_run(input logic [7:0] exp_cnt, input string tag);
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cnt"}, 32'(match_count), 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; cfg_limit = 8'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_detect", 32'(detect), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_cnt", 32'(match_count), 32'd0);

    // Non-overlapping 1001 on stream 1001001: only one match.
    start_run(8'b1001, 4'd4, 1'b0, 8'd0);
    bitin(1, 0, "no_b1"); bitin(0, 0, "no_b2"); bitin(0, 0, "no_b3"); bitin(1, 1, "no_b4");
    bitin(0, 0, "no_b5"); bitin(0, 0, "no_b6"); bitin(1, 0, "no_b7");
    chk("no_cnt", 32'(match_count), 32'd1);
    abort_run(8'd1, "no_abort");

    // Same stream, overlapping: second match after bit 7.
    start_run(8'b1001, 4'd4, 1'b1, 8'd0);
    chk("ov_cnt_clr", 32'(match_count), 32'd0);
    bitin(1, 0, "ov_b1"); bitin(0, 0, "ov_b2"); bitin(0, 0, "ov_b3"); bitin(1, 1, "ov_b4");
    bitin(0, 0, "ov_b5"); bitin(0, 0, "ov_b6"); bitin(1, 1, "ov_b7");
    chk("ov_cnt", 32'(match_count), 32'd2);
    abort_run(8'd2, "ov_abort");

    // Limit 3 on 11 overlapping: done with the third detect, in_ready drops.
    start_run(8'b11, 4'd2, 1'b1, 8'd3);
    bitin(1, 0, "lim_b1"); bitin(1, 1, "lim_b2"); bitin(1, 1, "lim_b3");
    chk("lim_done_early", 32'(done), 32'd0);
    bitin(1, 1, "lim_b4");
    chk("lim_done", 32'(done), 32'd1);
    chk("lim_ready", 32'(in_ready), 32'd0);
    chk("lim_busy", 32'(busy), 32'd0);
    chk("lim_cnt", 32'(match_count), 32'd3);
    bitin(1, 0, "lim_b5");
    chk("lim_done_once", 32'(done), 32'd0);
    bitin(1, 0, "lim_b6");
    chk("lim_cnt_held", 32'(match_count), 32'd3);
    chk("lim_idle_ready", 32'(in_ready), 32'd0);

    // 1001 with stalls, then abort mid-pattern.
    start_run(8'b1001, 4'd4, 1'b0, 8'd0);
    bitin(1, 0, "st_b1"); gap("st_g1"); bitin(0, 0, "st_b2"); gap("st_g2"); gap("st_g3");
    bitin(0, 0, "st_b3"); gap("st_g4"); bitin(1, 1, "st_b4");
    chk("st_cnt", 32'(match_count), 32'd1);
    bitin(1, 0, "st_b5"); bitin(0, 0, "st_b6");
    // start while busy is ignored (a bad length here must not raise cfg_err)
    in_valid = 1'b0; start = 1'b1; cfg_len = 4'd0;
    tick();
    start = 1'b0;
    chk("busy_start_err", 32'(cfg_err), 32'd0);
    chk("busy_start_ready", 32'(in_ready), 32'd1);
    abort_run(8'd1, "st_abort");
    tick();
    chk("st_abort_done", 32'(done), 32'd0);

    // Abort in the same cycle as a completing bit still counts the match.
    start_run(8'b1, 4'd1, 1'b0, 8'd0);
    in_valid = 1'b1; in_bit = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("ab_hit_det", 32'(detect), 32'd1);
    chk("ab_hit_cnt", 32'(match_count), 32'd1);
    chk("ab_hit_busy", 32'(busy), 32'd0);

    // Rejected starts.
    cfg_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_err", 32'(cfg_err), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    tick();
    chk("len0_err_pulse", 32'(cfg_err), 32'd0);
    cfg_len = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len9_err", 32'(cfg_err), 32'd1);
    chk("len9_busy", 32'(busy), 32'd0);
    chk("len9_cnt_held", 32'(match_count), 32'd1);

    // Full 8-bit pattern with window at PAT_W.
    start_run(8'b1010_0110, 4'd8, 1'b0, 8'd1);
    bitin(1, 0, "w8_b1"); bitin(0, 0, "w8_b2"); bitin(1, 0, "w8_b3"); bitin(0, 0, "w8_b4");
    bitin(0, 0, "w8_b5"); bitin(1, 0, "w8_b6"); bitin(1, 0, "w8_b7"); bitin(0, 1, "w8_b8");
    chk("w8_done", 32'(done), 32'd1);
    in_valid = 1'b0;
    tick();

    // Reset in SCAN after a match.
    start_run(8'b1, 4'd1, 1'b1, 8'd0);
    bitin(1, 1, "rs_b1");
    in_valid = 1'b1; in_bit = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rs_ready", 32'(in_ready), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_detect", 32'(detect), 32'd0);
    chk("rs_cnt", 32'(match_count), 32'd0);
    tick();
    chk("rs_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-controlled serial pattern matcher for programmable bit patterns, up to PAT_W bits long.
- Software or upstream logic loads a pattern and length, pulses start, then streams bits.
- The block sequences arm/scan/done, pulses detect on each match, counts matches and stops after a programmed match limit.
- Generalises the team's fixed-pattern detectors into a shared, configurable scan engine.

Parameters:
- PAT_W, 8: maximum pattern length in bits.
- LEN_W, 4: width of cfg_len. Must satisfy 2^LEN_W > PAT_W.
- CNT_W, 8: width of the match counter and of cfg_limit.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- abort  in  1  ends a run immediately; returns to IDLE.
- cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is the first bit received.
- cfg_len  in  LEN_W  pattern length, legal range 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cfg_limit  in  CNT_W  matches before done; 0 = unlimited.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit.
- in_ready  out  1  high in SCAN only; a bit is consumed when in_valid && in_ready.
- busy  out  1  high in ARM and SCAN.
- detect  out  1  one-cycle match pulse.
- done  out  1  one-cycle pulse when a run finishes by reaching the limit.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- match_count  out  CNT_W  matches in the current or last run; held after done.

Behaviour:
- Reset: state=IDLE. in_ready, busy, detect, done and cfg_err are 0; match_count=0; history and fill counter are cleared.
- States: IDLE, ARM, SCAN, DONE.
- IDLE, start with cfg_len in 1..PAT_W:
  - latch pattern, len, overlap and limit into shadow registers;
  - clear match_count, history and fill counter;
  - go to ARM.
- IDLE, start with cfg_len=0 or cfg_len>PAT_W: cfg_err=1 for the next cycle; stay in IDLE.
- ARM: lasts exactly one cycle; in_ready=0; then go to SCAN. Config inputs are ignored after latching and may change freely.
- SCAN, on each accepted bit:
  - hist <= {hist[PAT_W-2:0], in_bit};
  - fill <= min(fill+1, PAT_W).
- Match condition: fill_next >= len and the low len bits of hist_next equal shadow_pattern[len-1:0].
  - Evaluated on the updated history, i.e. including the bit accepted this cycle.
- On match:
  - detect=1 on the cycle after the completing bit is accepted (latency 1);
  - match_count increments, saturating at all-ones;
  - if overlap=0, fill is cleared to 0 so the next match needs len fresh bits;
  - if overlap=1, fill is kept.
- Limit reached (limit≠0 and the incremented count == limit):
  - go to DONE; in_ready drops on the following cycle;
  - no further bits are accepted.
- Cycles with in_valid=0 do not change history; they are stalls.
- DONE: done=1 for one cycle, coinciding with the final detect pulse; then IDLE.
- abort: in ARM or SCAN, go to IDLE next cycle.
  - No done pulse; match_count holds its value.
  - A match on the same cycle as abort still pulses detect and counts.
- abort in IDLE or DONE: no effect.
- start while busy: ignored.
- rst mid-run: everything returns to reset values on the next edge, regardless of any other input.
- Window width: comparison uses only the low len bits; history bits above len are don't-care.

Optional Feature:
- Macro SEQ_DETECT_CTRL_TIMEOUT_EN.
- When defined:
  - adds parameter TO_W (default 16) and input cfg_timeout[TO_W-1:0], latched at start;
  - adds output timeout, a one-cycle pulse.
- Timeout counter:
  - counts SCAN cycles since entering SCAN or since the last match;
  - resets on each match;
  - when it equals cfg_timeout (nonzero), the block pulses timeout and goes to IDLE with no done pulse;
  - cfg_timeout=0 disables it.
- When undefined: no port, no parameter, no counter; behaviour is exactly as above.

Test Plan:
- Basic non-overlap: pattern=0b1001, len=4, overlap=0, limit=0; stream 1,0,0,1,0,0,1 -> single detect pulse one cycle after the 4th bit; match_count=1.
- Overlap: same stream with overlap=1 -> detect after bit 4 and after bit 7; match_count=2.
- Limit: pattern=0b11, len=2, overlap=1, limit=3; stream eight 1s -> detects after bits 2, 3 and 4; done coincides with the 3rd detect; in_ready=0 from the next cycle; match_count=3.
- Stalls and abort: bits of 1001 interleaved with in_valid=0 gaps -> match still detected; then abort mid-pattern -> IDLE next cycle, no done, count held.
- Config error and reset: start with cfg_len=0 -> cfg_err pulse, stays IDLE; start with cfg_len=9 (PAT_W=8) -> cfg_err; rst asserted while in SCAN -> all outputs return to 0 next edge.
- Timeout (macro on): cfg_timeout=5, no matching bits -> timeout pulse after 5 SCAN cycles, then IDLE.
